// File: rtl/vga_timing_xga.sv
// vga_timing_xga: free-running raster timing generator for 1024x768 @ 60 Hz.
// Counters, blanking flags, sync pulses and frame strobe all come out of one
// register stage, so every output describes the same pixel in every cycle.
// Each blanking and sync interval must be at least one pixel or line wide,
// with H_TOTAL <= 2048 and V_TOTAL <= 1024.
module vga_timing_xga #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Interval bounds as inclusive full-width constants, so every compare is
  // done at the counter's own width.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_BLANK      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        hblnk_next;
  logic        vblnk_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        frame_start_next;
  logic [7:0]  frame_cnt_next;

  // Next raster position and the flags that belong to that position.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    h_wrap           = (hcount == H_LAST);
    v_wrap           = (vcount == V_LAST);
    h_next           = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next           = vcount;
    frame_start_next = 1'b0;
    frame_cnt_next   = frame_cnt;

    // vcount moves only when the line wraps, so vsync and vblnk can only
    // change on the cycle that lands on hcount = 0.
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vcount + 10'd1;
    end

    if (h_wrap && v_wrap) begin
      frame_start_next = 1'b1;
      frame_cnt_next   = frame_cnt + 8'd1;
    end

    hblnk_next = (h_next >= H_BLANK);
    vblnk_next = (v_next >= V_BLANK);
    hsync_next = (h_next >= H_SYNC_FIRST && h_next <= H_SYNC_LAST) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next = (v_next >= V_SYNC_FIRST && v_next <= V_SYNC_LAST) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Register the whole output set in one step; reset parks at pixel (0,0).
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= hblnk_next;
      vblnk       <= vblnk_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= frame_start_next;
      frame_cnt   <= frame_cnt_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_xga.sv
// tb_vga_timing_xga: three generator instances (default XGA timing, short
// lines with full-height frame, tiny frame) checked every cycle against a
// model that derives the raster state from the cycle count since reset.
module tb_vga_timing_xga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Output bundle layout: {hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start, frame_cnt}
  logic [10:0] hcount_a, hcount_b, hcount_c;
  logic [9:0]  vcount_a, vcount_b, vcount_c;
  logic        hblnk_a, hblnk_b, hblnk_c;
  logic        vblnk_a, vblnk_b, vblnk_c;
  logic        hsync_a, hsync_b, hsync_c;
  logic        vsync_a, vsync_b, vsync_c;
  logic        fs_a, fs_b, fs_c;
  logic [7:0]  fcnt_a, fcnt_b, fcnt_c;
  logic [33:0] bus_a, bus_b, bus_c;

  assign bus_a = {hcount_a, vcount_a, hblnk_a, vblnk_a, hsync_a, vsync_a, fs_a, fcnt_a};
  assign bus_b = {hcount_b, vcount_b, hblnk_b, vblnk_b, hsync_b, vsync_b, fs_b, fcnt_b};
  assign bus_c = {hcount_c, vcount_c, hblnk_c, vblnk_c, hsync_c, vsync_c, fs_c, fcnt_c};

  vga_timing_xga u_dut_a (
    .clk(clk), .rst(rst_a), .hcount(hcount_a), .vcount(vcount_a),
    .hblnk(hblnk_a), .vblnk(vblnk_a), .hsync(hsync_a), .vsync(vsync_a),
    .frame_start(fs_a), .frame_cnt(fcnt_a)
  );

  vga_timing_xga #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .HSYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .hcount(hcount_b), .vcount(vcount_b),
    .hblnk(hblnk_b), .vblnk(vblnk_b), .hsync(hsync_b), .vsync(vsync_b),
    .frame_start(fs_b), .frame_cnt(fcnt_b)
  );

  vga_timing_xga #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .hcount(hcount_c), .vcount(vcount_c),
    .hblnk(hblnk_c), .vblnk(vblnk_c), .hsync(hsync_c), .vsync(vsync_c),
    .frame_start(fs_c), .frame_cnt(fcnt_c)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Raster state after t free-running cycles since reset (t = 0 is the reset state).
  function automatic logic [33:0] model(input int ha, input int hfp, input int hs, input int hbp,
                                        input int va, input int vfp, input int vs, input int vbp,
                                        input bit hp, input bit vp, input longint t);
    longint ht, vt, ft, h, v, fr;
    logic hb, vb, hsy, vsy, fs;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    ft  = ht * vt;
    h   = t % ht;
    v   = (t / ht) % vt;
    fr  = (t / ft) % 256;
    fs  = (t != 0) && (t % ft == 0);
    hb  = (h >= ha);
    vb  = (v >= va);
    hsy = (h >= ha + hfp && h < ha + hfp + hs) ? hp : !hp;
    vsy = (v >= va + vfp && v < va + vfp + vs) ? vp : !vp;
    return {h[10:0], v[9:0], hb, vb, hsy, vsy, fs, fr[7:0]};
  endfunction

  longint t_a = 0, t_b = 0, t_c = 0;
  logic   ra_s, rb_s, rc_s;
  logic   ra_prev = 1'b1;
  logic   vs_prev_b = 1'b1;
  longint cyc_c = 0, ref_c = 0;
  int     exp_fc = 0;
  int     fs_total_c = 0;

  // Instance A: default XGA timing.
  always @(posedge clk) begin
    ra_s = rst_a;
    #1;
    t_a = ra_s ? 0 : t_a + 1;
    check("A_out", bus_a, model(1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, t_a));
    if (ra_prev && !ra_s) check("A_first_pixel", 34'({hcount_a, vcount_a}), 34'({11'd1, 10'd0}));
    ra_prev = ra_s;
  end

  // Instance B: short lines, full-height frame; vsync may only move at hcount 0.
  always @(posedge clk) begin
    rb_s = rst_b;
    #1;
    t_b = rb_s ? 0 : t_b + 1;
    check("B_out", bus_b, model(8, 1, 2, 1, 768, 3, 6, 29, 1'b1, 1'b0, t_b));
    if (!rb_s && vsync_b != vs_prev_b) check("B_vsync_at_h0", 34'(hcount_b), 34'd0);
    vs_prev_b = vsync_b;
  end

  // Instance C: 12x7 frame; strobe spacing and frame count tracked independently.
  always @(posedge clk) begin
    rc_s = rst_c;
    #1;
    t_c = rc_s ? 0 : t_c + 1;
    cyc_c++;
    check("C_out", bus_c, model(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, t_c));
    if (rc_s) begin
      ref_c  = cyc_c;
      exp_fc = 0;
      check("C_rst_cnt", 34'(fcnt_c), 34'd0);
    end else if (fs_c) begin
      check("C_period", 34'(cyc_c - ref_c), 34'd84);
      ref_c  = cyc_c;
      exp_fc = (exp_fc + 1) % 256;
      check("C_frame_cnt", 34'(fcnt_c), 34'(exp_fc));
      fs_total_c++;
    end
  end

  logic [2:0] mask;
  int         len;

  initial begin
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    // 257 tiny frames plus a few cycles: two full B frames and 16 A lines.
    repeat (257 * 84 + 5) @(negedge clk);
    check("C_fs_total", 34'(fs_total_c), 34'd257);

    // Random mid-line / mid-frame resets on random subsets of instances.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(50, 3000)) @(negedge clk);
      mask  = 3'($urandom_range(1, 7));
      len   = $urandom_range(1, 5);
      rst_a = mask[0];
      rst_b = mask[1];
      rst_c = mask[2];
      repeat (len) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
    end

    // C: reset somewhere inside the fourth frame, then watch the recovery.
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    repeat (3 * 84 + $urandom_range(1, 83)) @(negedge clk);
    rst_c = 1'b1;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    rst_c = 1'b0;
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_xga.md
# vga_timing_xga

Raster timing generator for the 1024x768 @ 60 Hz display path. It runs on the 65 MHz pixel clock and produces the horizontal and vertical pixel counters, blanking flags and sync pulses. These drive the menu/background drawing stage and every later draw stage. It also emits a one-cycle frame-start strobe and a free-running frame counter, which game logic uses for per-frame updates.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync

Ports:
- clk  in  1  pixel clock, 65 MHz; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- hblnk  out  1  high while hcount >= H_ACTIVE
- vblnk  out  1  high while vcount >= V_ACTIVE
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- frame_start  out  1  one-cycle strobe on the cycle the outputs wrap to (0,0)
- frame_cnt  out  8  frames completed since reset, modulo 256

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 1344 with the defaults.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 806 with the defaults.
- Horizontal counter:
  - increments every cycle
  - wraps from H_TOTAL-1 to 0
- Vertical counter:
  - increments only on the cycle hcount wraps
  - wraps from V_TOTAL-1 to 0 when both counters are at their maximum
- Flag definitions:
  - hsync is active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
  - vsync is active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776.
  - hblnk is set for 1024..1343; vblnk is set for 768..805.
  - Each flag is inactive everywhere else.
- vsync is a whole-line signal: it changes only together with a vcount change, at hcount = 0.
- Outputs are registered together as one set: in any cycle, all flags describe the same (hcount, vcount) pixel shown on the counter outputs.
  - Implementation: compute the next counter values combinationally, derive the next flags from those next values, and register everything in one step.
- frame_start and frame_cnt:
  - frame_start is high exactly when the registered outputs step from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - frame_cnt increments in the same cycle and wraps 255 -> 0.
- No enable and no stall: the generator free-runs whenever rst is low.

## Timing
- Reset values, held for every cycle rst is high:
  - hcount = 0, vcount = 0
  - hblnk = 0, vblnk = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - frame_start = 0, frame_cnt = 0
- First cycle after rst falls: outputs are (1,0). The (0,0) pixel is the reset state itself, so the first frame after reset has no frame_start strobe.
- Line period: H_TOTAL cycles.
- Frame period: H_TOTAL*V_TOTAL cycles, which is 1,083,264 with the defaults.
- frame_start pulses are exactly one frame period apart.
- hblnk rise / hsync assert:
  - hblnk rises in the same cycle hcount reaches 1024.
  - hsync asserts at hcount 1048 and deasserts at 1184.
- Reset mid-frame: on the next edge, all outputs return to the reset values, regardless of counter position. No partial-frame pulse and no frame_cnt increment.
- Width rules:
  - Counters compare at full 11/10-bit width.
  - Parameters must give H_TOTAL <= 2048 and V_TOTAL <= 1024.

## Test plan
- Reset: hold rst for 5 cycles, mid-frame at (500,300) -> all outputs at reset values; first post-reset sample is hcount=1, vcount=0.
- Horizontal line: run one line from reset, defaults ->
  - hblnk 0 for hcount 0..1023, 1 for 1024..1343
  - hsync low exactly for 1048..1183
  - hcount wraps 1343 -> 0, vcount increments to 1 in that same cycle
- Vertical frame: run one full frame ->
  - vblnk set for lines 768..805
  - vsync low for lines 771..776, changing only at hcount=0
  - wrap (1343,805) -> (0,0), with frame_start=1 for exactly that one cycle and frame_cnt=1
- Frame cadence, small overrides (H: 8/1/2/1, V: 4/1/1/1, HSYNC_POL=1) ->
  - H_TOTAL 12, V_TOTAL 7
  - frame_start every 84 cycles
  - hsync high only at hcount 9..10
- frame_cnt wrap, small parameters, 257 frames -> frame_cnt reads 255 then 0 then 1.
- Reset mid-frame after 3 frames (frame_cnt=3) -> frame_cnt=0 next cycle; the next frame_start arrives exactly H_TOTAL*V_TOTAL cycles after rst falls.
